// File: rtl/irq_controller_if.sv
// Bundle of the source, mask and core-handshake signals around irq_controller.
// The master side drives the sources, the mask writes and the core's ack/done;
// the slave side is the controller itself.
`timescale 1ns/1ps
interface irq_controller_if #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 4
);
  logic [N_SRC-1:0]   irq_src;
  logic               mask_we;
  logic [N_SRC-1:0]   mask_wdata;
  logic               irq_ack;
  logic               irq_done;
  logic               interrupt;
  logic [CAUSE_W-1:0] irq_cause;
  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   mask;
  logic [15:0]        irq_count;

  modport master (
    output irq_src, mask_we, mask_wdata, irq_ack, irq_done,
    input  interrupt, irq_cause, pending, mask, irq_count
  );

  modport slave (
    input  irq_src, mask_we, mask_wdata, irq_ack, irq_done,
    output interrupt, irq_cause, pending, mask, irq_count
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt request controller: edge-detects sources, latches them as pending,
// masks them and presents one fixed-priority request at a time to the core.
//
// Handshake: interrupt/irq_cause rise together and stay stable until irq_ack
// is sampled high; that edge drops interrupt, retires the pending bit and
// counts the interrupt. No new request is raised until irq_done is sampled
// high. irq_ack outside REQ and irq_done outside SERVICE are ignored; in REQ
// an ack coinciding with done is treated as the ack alone.
`timescale 1ns/1ps
module irq_controller #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  irq_controller_if.slave  bus,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   src_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic               interrupt_q, interrupt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [15:0]        irq_count_q, irq_count_d;

  logic [N_SRC-1:0]   fire;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   clr;
  logic [CAUSE_W-1:0] winner;

  assign fire     = bus.irq_src & ~src_q;
  assign eligible = pending_q & mask_q;

  // Lowest set eligible index wins; scanning downward lets the lowest overwrite.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CAUSE_W'(i);
    end
  end

  // Next-state and registered-output logic for the request FSM.
  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    cause_d     = cause_q;
    irq_count_d = irq_count_q;
    clr         = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
          cause_d     = winner;
        end
      end
      REQ: begin
        // Request is held even if its source gets masked meanwhile.
        if (bus.irq_ack) begin
          for (int i = 0; i < N_SRC; i++) begin
            if (cause_q == CAUSE_W'(i)) clr[i] = 1'b1;
          end
          irq_count_d = irq_count_q + 16'd1;
          interrupt_d = 1'b0;
          state_d     = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.irq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fire is OR-ed after the clear so a same-edge re-fire is never lost.
  always_comb begin
    pending_d = (pending_q & ~clr) | fire;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  // State registers; reset drops everything, including pending interrupts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      pending_q   <= '0;
      mask_q      <= '1;
      interrupt_q <= 1'b0;
      cause_q     <= '0;
      irq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= bus.irq_src;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      interrupt_q <= interrupt_d;
      cause_q     <= cause_d;
      irq_count_q <= irq_count_d;
    end
  end

  assign bus.interrupt = interrupt_q;
  assign bus.irq_cause = cause_q;
  assign bus.pending   = pending_q;
  assign bus.mask      = mask_q;
  assign bus.irq_count = irq_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
`timescale 1ns/1ps
module tb_irq_controller;

  localparam int N_SRC   = 4;
  localparam int CAUSE_W = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         n_pass;
  int         n_total;
  int         seen;

  irq_controller_if #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W)) bus ();

  irq_controller #(.N_SRC(N_SRC), .CAUSE_W(CAUSE_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Clock: rising edges at 5, 15, 25 ...; bench drives and samples on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_done();
    bus.irq_done = 1'b1;
    tick();
    bus.irq_done = 1'b0;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] v);
    bus.irq_src = v;
    tick();
    bus.irq_src = '0;
  endtask

  task automatic write_mask(input logic [N_SRC-1:0] v);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = v;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.irq_src = '0;
    bus.mask_we = 1'b0;
    bus.mask_wdata = '0;
    bus.irq_ack = 1'b0;
    bus.irq_done = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_interrupt", 32'(bus.interrupt), 32'd0);
    check("rst_cause", 32'(bus.irq_cause), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_mask", 32'(bus.mask), 32'hF);
    check("rst_count", 32'(bus.irq_count), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    rst = 1'b0;
    tick();

    // Single source 2: pending after edge k, request after k+1
    pulse(4'b0100);
    check("single_pending", 32'(bus.pending), 32'h4);
    check("single_no_irq_yet", 32'(bus.interrupt), 32'd0);
    tick();
    check("single_irq", 32'(bus.interrupt), 32'd1);
    check("single_cause", 32'(bus.irq_cause), 32'd2);
    tick();
    tick();
    check("single_hold", 32'(bus.interrupt), 32'd1);
    do_ack();
    check("single_ack_irq", 32'(bus.interrupt), 32'd0);
    check("single_ack_pending", 32'(bus.pending), 32'd0);
    check("single_ack_count", 32'(bus.irq_count), 32'd1);
    check("single_service", 32'(state), 32'(S_SERV));
    tick();
    tick();
    do_done();
    check("single_done_idle", 32'(state), 32'(S_IDLE));
    tick();
    tick();
    check("single_no_more", 32'(bus.interrupt), 32'd0);

    // Priority: sources 3 and 1 together, 1 first
    pulse(4'b1010);
    check("prio_pending", 32'(bus.pending), 32'hA);
    tick();
    check("prio_first_cause", 32'(bus.irq_cause), 32'd1);
    do_ack();
    check("prio_left_pending", 32'(bus.pending), 32'h8);
    tick();
    check("prio_svc_quiet", 32'(bus.interrupt), 32'd0);
    do_done();
    check("prio_done_quiet", 32'(bus.interrupt), 32'd0);
    tick();
    check("prio_second_irq", 32'(bus.interrupt), 32'd1);
    check("prio_second_cause", 32'(bus.irq_cause), 32'd3);
    do_ack();
    do_done();
    check("prio_count", 32'(bus.irq_count), 32'd3);

    // Mask: source 0 masked stays latched, released by unmask
    write_mask(4'b1110);
    check("mask_written", 32'(bus.mask), 32'hE);
    pulse(4'b0001);
    check("mask_pending", 32'(bus.pending), 32'h1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.interrupt) seen++;
    end
    check("mask_blocked", 32'(seen), 32'd0);
    write_mask(4'b1111);
    check("unmask_one_edge", 32'(bus.interrupt), 32'd0);
    tick();
    check("unmask_irq", 32'(bus.interrupt), 32'd1);
    check("unmask_cause", 32'(bus.irq_cause), 32'd0);

    // Stray done in REQ is ignored
    do_done();
    check("stray_done_state", 32'(state), 32'(S_REQ));
    check("stray_done_irq", 32'(bus.interrupt), 32'd1);
    do_ack();
    do_done();
    check("mask_count", 32'(bus.irq_count), 32'd4);

    // Set-over-clear: source 2 re-fires on the ack edge
    pulse(4'b0100);
    tick();
    check("soc_cause", 32'(bus.irq_cause), 32'd2);
    bus.irq_src = 4'b0100;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_src = '0;
    bus.irq_ack = 1'b0;
    check("soc_pending_kept", 32'(bus.pending), 32'h4);
    check("soc_irq_low", 32'(bus.interrupt), 32'd0);
    check("soc_count", 32'(bus.irq_count), 32'd5);
    do_done();
    tick();
    check("soc_rerequest", 32'(bus.interrupt), 32'd1);
    check("soc_recause", 32'(bus.irq_cause), 32'd2);
    do_ack();
    check("soc_cleared", 32'(bus.pending), 32'd0);
    do_done();

    // Stray ack in IDLE is ignored
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check("stray_ack_count", 32'(bus.irq_count), 32'd6);
    check("stray_ack_state", 32'(state), 32'(S_IDLE));

    // Async reset mid-REQ with pending 0101 and a non-default mask
    write_mask(4'b0011);
    pulse(4'b0101);
    tick();
    check("prerst_state", 32'(state), 32'(S_REQ));
    check("prerst_pending", 32'(bus.pending), 32'h5);
    #2 rst = 1'b1;
    #1;
    check("arst_interrupt", 32'(bus.interrupt), 32'd0);
    check("arst_pending", 32'(bus.pending), 32'd0);
    check("arst_mask", 32'(bus.mask), 32'hF);
    check("arst_count", 32'(bus.irq_count), 32'd0);
    check("arst_state", 32'(state), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Counter wrap: preload to 0xFFFF, then one more ack
    force dut.irq_count_q = 16'hFFFF;
    #1;
    release dut.irq_count_q;
    tick();
    check("wrap_preload", 32'(bus.irq_count), 32'hFFFF);
    pulse(4'b0010);
    tick();
    check("wrap_cause", 32'(bus.irq_cause), 32'd1);
    do_ack();
    check("wrap_count", 32'(bus.irq_count), 32'd0);
    do_done();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
